// File: rtl/mcp_pkg.sv
// mcp_pkg: shared definitions for the microsequencer.
//   - sequencing command encodings carried in the microword (seq_op_e)
//   - microROM geometry: LC_W address bits, MO_W word bits
//   - default reset vector
//   - sequencer FSM state encoding
package mcp_pkg;

    localparam int LC_W = 11;
    localparam int MO_W = 22;

    localparam logic [LC_W-1:0] RESET_VEC_DEF = 11'h000;

    typedef enum logic [2:0] {
        SEQ_NEXT = 3'd0,
        SEQ_JMP  = 3'd1,
        SEQ_CJMP = 3'd2,
        SEQ_CALL = 3'd3,
        SEQ_RET  = 3'd4,
        SEQ_TRAP = 3'd5
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mcp_rstack.sv
// mcp_rstack: return-address LIFO for the microsequencer.
// Ports:
//   clk, srst        clock, synchronous active-high reset (empties the stack)
//   i_push, i_data   push i_data; ignored when full
//   i_pop            pop the top entry; ignored when empty
//   o_top            current top entry (valid when not empty)
//   o_count          occupancy 0..DEPTH
//   o_full, o_empty  occupancy flags
// The caller never pushes and pops in the same cycle.
module mcp_rstack
    import mcp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SP_W  = 2
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            i_push,
    input  logic [LC_W-1:0] i_data,
    input  logic            i_pop,
    output logic [LC_W-1:0] o_top,
    output logic [SP_W:0]   o_count,
    output logic            o_full,
    output logic            o_empty
);

    logic [LC_W-1:0] r_mem [DEPTH];
    logic [SP_W:0]   r_cnt;
    logic [SP_W-1:0] w_wr_idx;
    logic [SP_W-1:0] w_top_idx;

    assign o_full    = (r_cnt == (SP_W+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_wr_idx  = r_cnt[SP_W-1:0];
    // DEPTH is a power of two, so at full the low bits are zero and the
    // subtraction wraps to DEPTH-1, which is the correct top slot.
    assign w_top_idx = r_cnt[SP_W-1:0] - SP_W'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_count   = r_cnt;

    // Entry contents carry no reset: only the occupancy count matters.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (i_push && !o_full && (w_wr_idx == SP_W'(gi))) begin
                r_mem[gi] <= i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_cnt <= r_cnt + (SP_W+1)'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - (SP_W+1)'(1);
        end
    end

endmodule

// File: rtl/mcp_seq.sv
// mcp_seq: microsequencer producing the 11-bit location counter for a
// 2048 x 22 synchronous microROM (word returned one clock after address).
// Ports:
//   pin_clk, pin_rst   clock, synchronous active-high reset
//   pin_op             sequencing command of the current microword
//   pin_ba             branch/call target
//   pin_cond           CJMP condition
//   pin_ta, pin_tv     translation dispatch address and its valid
//   pin_wait           hold request, freezes sequencing
//   pin_lc             location counter (registered) to the ROM address
//   pin_mv             microword valid
//   pin_sp             return-stack occupancy 0..STACK_DEPTH
//   pin_err            sticky error flag, cleared only by reset
module mcp_seq
    import mcp_pkg::*;
#(
    parameter logic [LC_W-1:0] RESET_VEC   = RESET_VEC_DEF,
    parameter int              STACK_DEPTH = 4,
    parameter int              SP_W        = 2
) (
    input  logic            pin_clk,
    input  logic            pin_rst,
    input  logic [2:0]      pin_op,
    input  logic [LC_W-1:0] pin_ba,
    input  logic            pin_cond,
    input  logic [LC_W-1:0] pin_ta,
    input  logic            pin_tv,
    input  logic            pin_wait,
    output logic [LC_W-1:0] pin_lc,
    output logic            pin_mv,
    output logic [SP_W:0]   pin_sp,
    output logic            pin_err
);

    seq_state_e      r_state, w_state_next;
    logic [LC_W-1:0] r_lc, w_lc_next;
    logic            r_mv, w_mv_next;
    logic            r_err, w_err_next;
    logic            w_push, w_pop;
    logic [LC_W-1:0] w_inc;
    logic [LC_W-1:0] w_top;
    logic            w_full, w_empty;

    // 11-bit add wraps 0x7FF to 0x000 on its own.
    assign w_inc = r_lc + LC_W'(1);

    mcp_rstack #(
        .DEPTH (STACK_DEPTH),
        .SP_W  (SP_W)
    ) u_rstack (
        .clk     (pin_clk),
        .srst    (pin_rst),
        .i_push  (w_push),
        .i_data  (w_inc),
        .i_pop   (w_pop),
        .o_top   (w_top),
        .o_count (pin_sp),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            r_state <= ST_FILL;
            r_lc    <= RESET_VEC;
            r_mv    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_lc    <= w_lc_next;
            r_mv    <= w_mv_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lc_next    = r_lc;
        w_mv_next    = r_mv;
        w_err_next   = r_err;
        w_push       = 1'b0;
        w_pop        = 1'b0;

        case (r_state)
            ST_FILL: begin
                // ROM is fetching RESET_VEC; its word is valid next cycle.
                w_mv_next    = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN, ST_WAIT: begin
                if (pin_wait) begin
                    // Hold everything; the pending command is re-evaluated
                    // on the first edge with the wait released.
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_RUN;
                    case (pin_op)
                        SEQ_NEXT: w_lc_next = w_inc;
                        SEQ_JMP:  w_lc_next = pin_ba;
                        SEQ_CJMP: w_lc_next = pin_cond ? pin_ba : w_inc;
                        SEQ_CALL: begin
                            // Jump is taken even when the push is lost.
                            w_lc_next = pin_ba;
                            if (w_full) begin
                                w_err_next = 1'b1;
                            end else begin
                                w_push = 1'b1;
                            end
                        end
                        SEQ_RET: begin
                            if (w_empty) begin
                                w_lc_next  = RESET_VEC;
                                w_err_next = 1'b1;
                            end else begin
                                w_lc_next = w_top;
                                w_pop     = 1'b1;
                            end
                        end
                        SEQ_TRAP: begin
                            if (pin_tv) begin
                                w_lc_next = pin_ta;
                            end else begin
                                w_lc_next  = w_inc;
                                w_err_next = 1'b1;
                            end
                        end
                        default: begin
                            // Reserved encodings behave as NEXT.
                            w_lc_next  = w_inc;
                            w_err_next = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                w_state_next = ST_FILL;
                w_lc_next    = RESET_VEC;
                w_mv_next    = 1'b0;
            end
        endcase
    end

    assign pin_lc  = r_lc;
    assign pin_mv  = r_mv;
    assign pin_err = r_err;

endmodule

// File: tb/tb_mcp_seq.sv
module tb_mcp_seq;
    import mcp_pkg::*;

    logic        pin_clk = 1'b0;
    logic        pin_rst;
    logic [2:0]  pin_op;
    logic [10:0] pin_ba;
    logic        pin_cond;
    logic [10:0] pin_ta;
    logic        pin_tv;
    logic        pin_wait;
    logic [10:0] pin_lc;
    logic        pin_mv;
    logic [2:0]  pin_sp;
    logic        pin_err;

    int checks = 0;
    int errors = 0;

    always #5 pin_clk = ~pin_clk;

    mcp_seq #(
        .RESET_VEC   (11'h000),
        .STACK_DEPTH (4),
        .SP_W        (2)
    ) dut (
        .pin_clk  (pin_clk),
        .pin_rst  (pin_rst),
        .pin_op   (pin_op),
        .pin_ba   (pin_ba),
        .pin_cond (pin_cond),
        .pin_ta   (pin_ta),
        .pin_tv   (pin_tv),
        .pin_wait (pin_wait),
        .pin_lc   (pin_lc),
        .pin_mv   (pin_mv),
        .pin_sp   (pin_sp),
        .pin_err  (pin_err)
    );

    // One clock edge, outputs sampled 1 ns later, one line per transaction.
    task automatic step();
        @(posedge pin_clk);
        #1;
        $display("edge rst=%0b op=%0d ba=%h wait=%0b -> lc=%h mv=%0b sp=%0d err=%0b",
                 pin_rst, pin_op, pin_ba, pin_wait, pin_lc, pin_mv, pin_sp, pin_err);
    endtask

    // Reset and pass through FILL, leaving LC=000 in RUN.
    task automatic go_reset();
        pin_rst = 1'b1; pin_op = 3'(SEQ_NEXT); pin_wait = 1'b0; pin_tv = 1'b0;
        step();
        pin_rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        pin_rst = 1'b1; pin_op = 3'(SEQ_NEXT); pin_ba = '0; pin_cond = 1'b0;
        pin_ta = '0; pin_tv = 1'b0; pin_wait = 1'b0;
        step();
        checks++;
        if (pin_lc !== 11'h000 || pin_mv !== 1'b0 || pin_sp !== 3'd0 || pin_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state lc=%h mv=%b sp=%0d err=%b expected lc=000 mv=0 sp=0 err=0",
                     pin_lc, pin_mv, pin_sp, pin_err);
        end
        pin_rst = 1'b0;
        step();
        checks++;
        if (pin_lc !== 11'h000 || pin_mv !== 1'b1) begin
            errors++;
            $display("FAIL fill_exit lc=%h mv=%b expected lc=000 mv=1", pin_lc, pin_mv);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (pin_lc !== 11'(i) || pin_mv !== 1'b1) begin
                errors++;
                $display("FAIL next_%0d lc=%h mv=%b expected lc=%h mv=1", i, pin_lc, pin_mv, 11'(i));
            end
        end
    endtask

    task automatic test_branches();
        pin_op = 3'(SEQ_JMP); pin_ba = 11'h7FF;
        step();
        checks++;
        if (pin_lc !== 11'h7FF) begin
            errors++; $display("FAIL jmp_7ff lc=%h expected 7ff", pin_lc);
        end
        pin_op = 3'(SEQ_NEXT);
        step();
        checks++;
        if (pin_lc !== 11'h000) begin
            errors++; $display("FAIL wrap lc=%h expected 000", pin_lc);
        end
        pin_op = 3'(SEQ_JMP); pin_ba = 11'h5A3;
        step();
        checks++;
        if (pin_lc !== 11'h5A3) begin
            errors++; $display("FAIL jmp_5a3 lc=%h expected 5a3", pin_lc);
        end
        pin_op = 3'(SEQ_CJMP); pin_ba = 11'h100; pin_cond = 1'b0;
        step();
        checks++;
        if (pin_lc !== 11'h5A4) begin
            errors++; $display("FAIL cjmp_not_taken lc=%h expected 5a4", pin_lc);
        end
        pin_cond = 1'b1;
        step();
        checks++;
        if (pin_lc !== 11'h100) begin
            errors++; $display("FAIL cjmp_taken lc=%h expected 100", pin_lc);
        end
        pin_cond = 1'b0;
    endtask

    task automatic test_call_ret();
        pin_op = 3'(SEQ_JMP); pin_ba = 11'h010;
        step();
        pin_op = 3'(SEQ_CALL); pin_ba = 11'h200;
        step();
        checks++;
        if (pin_lc !== 11'h200 || pin_sp !== 3'd1) begin
            errors++; $display("FAIL call lc=%h sp=%0d expected lc=200 sp=1", pin_lc, pin_sp);
        end
        pin_op = 3'(SEQ_NEXT);
        step();
        checks++;
        if (pin_lc !== 11'h201 || pin_sp !== 3'd1) begin
            errors++; $display("FAIL call_next lc=%h sp=%0d expected lc=201 sp=1", pin_lc, pin_sp);
        end
        pin_op = 3'(SEQ_RET);
        step();
        checks++;
        if (pin_lc !== 11'h011 || pin_sp !== 3'd0 || pin_err !== 1'b0) begin
            errors++;
            $display("FAIL ret lc=%h sp=%0d err=%b expected lc=011 sp=0 err=0", pin_lc, pin_sp, pin_err);
        end
    endtask

    // Starts at LC=011 with an empty stack.
    task automatic test_stack_bounds();
        logic [10:0] exp_lc;
        logic [2:0]  exp_sp;
        for (int i = 0; i < 5; i++) begin
            pin_op = 3'(SEQ_CALL); pin_ba = 11'((i + 1) * 256);
            step();
            exp_sp = (i < 4) ? 3'(i + 1) : 3'd4;
            checks++;
            if (pin_lc !== 11'((i + 1) * 256) || pin_sp !== exp_sp || pin_err !== (i == 4)) begin
                errors++;
                $display("FAIL call_nest_%0d lc=%h sp=%0d err=%b expected lc=%h sp=%0d err=%b",
                         i, pin_lc, pin_sp, pin_err, 11'((i + 1) * 256), exp_sp, (i == 4));
            end
        end
        // Return addresses pushed: 012, 101, 201, 301 (bottom to top).
        for (int i = 0; i < 4; i++) begin
            pin_op = 3'(SEQ_RET);
            step();
            exp_lc = (i < 3) ? 11'((3 - i) * 256 + 1) : 11'h012;
            exp_sp = 3'(3 - i);
            checks++;
            if (pin_lc !== exp_lc || pin_sp !== exp_sp) begin
                errors++;
                $display("FAIL ret_nest_%0d lc=%h sp=%0d expected lc=%h sp=%0d",
                         i, pin_lc, pin_sp, exp_lc, exp_sp);
            end
        end
        pin_op = 3'(SEQ_RET);
        step();
        checks++;
        if (pin_lc !== 11'h000 || pin_sp !== 3'd0 || pin_err !== 1'b1) begin
            errors++;
            $display("FAIL ret_underflow lc=%h sp=%0d err=%b expected lc=000 sp=0 err=1",
                     pin_lc, pin_sp, pin_err);
        end
    endtask

    task automatic test_wait();
        go_reset();
        pin_op = 3'(SEQ_JMP); pin_ba = 11'h040;
        step();
        pin_ba = 11'h300; pin_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pin_lc !== 11'h040 || pin_mv !== 1'b1 || pin_sp !== 3'd0) begin
                errors++;
                $display("FAIL wait_hold_%0d lc=%h mv=%b sp=%0d expected lc=040 mv=1 sp=0",
                         i, pin_lc, pin_mv, pin_sp);
            end
        end
        pin_wait = 1'b0;
        step();
        checks++;
        if (pin_lc !== 11'h300) begin
            errors++; $display("FAIL wait_release lc=%h expected 300", pin_lc);
        end
    endtask

    task automatic test_trap();
        pin_op = 3'(SEQ_TRAP); pin_ta = 11'h6C0; pin_tv = 1'b1;
        step();
        checks++;
        if (pin_lc !== 11'h6C0 || pin_err !== 1'b0) begin
            errors++; $display("FAIL trap_valid lc=%h err=%b expected lc=6c0 err=0", pin_lc, pin_err);
        end
        pin_tv = 1'b0;
        step();
        checks++;
        if (pin_lc !== 11'h6C1 || pin_err !== 1'b1) begin
            errors++; $display("FAIL trap_invalid lc=%h err=%b expected lc=6c1 err=1", pin_lc, pin_err);
        end
    endtask

    task automatic test_reserved();
        go_reset();
        pin_op = 3'd6;
        step();
        checks++;
        if (pin_lc !== 11'h001 || pin_err !== 1'b1) begin
            errors++; $display("FAIL reserved_op lc=%h err=%b expected lc=001 err=1", pin_lc, pin_err);
        end
    endtask

    // Runs with pin_err already set, so reset must also clear it.
    task automatic test_reset_mid_call();
        pin_op = 3'(SEQ_CALL); pin_ba = 11'h250;
        step();
        checks++;
        if (pin_lc !== 11'h250 || pin_sp !== 3'd1) begin
            errors++; $display("FAIL pre_reset_call lc=%h sp=%0d expected lc=250 sp=1", pin_lc, pin_sp);
        end
        pin_rst = 1'b1;
        step();
        checks++;
        if (pin_lc !== 11'h000 || pin_sp !== 3'd0 || pin_err !== 1'b0 || pin_mv !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset lc=%h sp=%0d err=%b mv=%b expected lc=000 sp=0 err=0 mv=0",
                     pin_lc, pin_sp, pin_err, pin_mv);
        end
        // The CALL is still presented during FILL and must be ignored.
        pin_rst = 1'b0;
        step();
        checks++;
        if (pin_lc !== 11'h000 || pin_sp !== 3'd0 || pin_mv !== 1'b1) begin
            errors++;
            $display("FAIL fill_ignores_cmd lc=%h sp=%0d mv=%b expected lc=000 sp=0 mv=1",
                     pin_lc, pin_sp, pin_mv);
        end
    endtask

    initial begin
        test_reset();
        test_branches();
        test_call_ret();
        test_stack_bounds();
        test_wait();
        test_trap();
        test_reserved();
        test_reset_mid_call();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcp_seq.md
Name: mcp_seq

Overview:
- Microsequencer that generates the 11-bit location counter for the 2048 x 22 synchronous microROM; the ROM returns its word one clock after the address.
- Chooses the next address from the sequencing command decoded out of the current microword: increment, jump, conditional jump, call, return, translation dispatch.
- Adds a small return stack, wait-state hold and a validity flag, so the downstream microinstruction decoder knows when the microword bus is meaningful.

Parameters:
- RESET_VEC, 11'h000, LC loaded on reset.
- STACK_DEPTH, 4, return-stack entries (power of 2, 2..16).
- SP_W, 2, stack-pointer width = log2(STACK_DEPTH).

Ports:
- pin_clk  in  1  main clock; all state changes on rising edge.
- pin_rst  in  1  synchronous reset, active-high.
- pin_op  in  3  sequencing command for the current microword: 0 NEXT, 1 JMP, 2 CJMP, 3 CALL, 4 RET, 5 TRAP, 6/7 reserved (treated as NEXT, raise pin_err).
- pin_ba  in  11  branch/call target from the current microword.
- pin_cond  in  1  condition for CJMP.
- pin_ta  in  11  translation (dispatch) address from the instruction decoder.
- pin_tv  in  1  pin_ta valid.
- pin_wait  in  1  hold request (bus wait, refresh); freezes sequencing.
- pin_lc  out  11  location counter to the microROM address input.
- pin_mv  out  1  microword valid: pin_mo holds the word for the address issued last cycle.
- pin_sp  out  SP_W+1  stack occupancy, 0..STACK_DEPTH.
- pin_err  out  1  sticky error: stack overflow, stack underflow, reserved op, or TRAP without pin_tv.

Behaviour:
- Reset (pin_rst=1 at an edge, any state, also mid-operation):
  - pin_lc<=RESET_VEC, pin_mv<=0, pin_sp<=0, pin_err<=0, state<=FILL.
  - Stack contents are don't-care.
- States:
  - FILL: the ROM is fetching RESET_VEC. All command inputs are ignored. Next edge: pin_mv<=1, pin_lc unchanged, go to RUN.
  - RUN: commands are honoured only when pin_mv=1 and pin_wait=0.
  - WAIT: entered from RUN when pin_wait=1. Hold pin_lc, pin_sp and pin_mv. Because the ROM re-reads the same address, pin_mo stays stable. Return to RUN on the first edge with pin_wait=0; the command is evaluated in that same edge's cycle.
- Next LC in RUN (from current pin_lc = L):
  - NEXT: L+1, modulo 2048 (0x7FF wraps to 0x000).
  - JMP: pin_ba.
  - CJMP: pin_ba if pin_cond else L+1.
  - CALL: push L+1 (wrapped), LC<=pin_ba, sp+1.
  - RET: LC<=top, sp-1.
  - TRAP: pin_ta if pin_tv. If pin_tv=0, take L+1 and set pin_err.
- Latency: a command applied with microword at address L produces the word at the new address on pin_mo exactly 2 edges later. pin_mv stays 1 throughout (single-cycle pipeline, no bubble).
- Stack boundaries:
  - CALL at sp=STACK_DEPTH: jump still taken, push discarded, sp unchanged, pin_err<=1.
  - RET at sp=0: LC<=RESET_VEC, sp stays 0, pin_err<=1.
- Simultaneous events:
  - pin_rst dominates everything.
  - pin_wait dominates the command: the command is not consumed and is re-evaluated after the wait.
- pin_err clears only on reset.
- All outputs are registered; no combinational path from inputs to pin_lc.

Decomposition:
- Shared package mcp_pkg holds:
  - the op encodings (SEQ_NEXT..SEQ_TRAP);
  - LC_W=11 and MO_W=22;
  - RESET_VEC default.
- One natural sub-module: mcp_rstack, a LIFO of STACK_DEPTH x 11 with push/pop/full/empty.
- Sequencer FSM and next-address mux stay in mcp_seq.
- Top-level integration pairs mcp_seq with mcp1631 on the shared pin_clk.

Test Plan:
- Reset release with NEXT ops -> pin_lc=000 (FILL, pin_mv=0), then 000 with pin_mv=1, then 001, 002, 003 on successive edges.
- LC at 7FF with NEXT -> next pin_lc=000; JMP ba=5A3 -> 5A3; CJMP ba=100 cond=0 at 5A3 -> 5A4, cond=1 -> 100.
- CALL ba=200 at 010, then NEXT, then RET at 201 -> sequence 010, 200, 201, 011; pin_sp 0->1->1->0.
- Five nested CALLs with STACK_DEPTH=4 -> fifth jumps but pin_sp stays 4 and pin_err=1. RET at sp=0 -> pin_lc=000, pin_err=1.
- pin_wait high 3 cycles at LC=040 with op JMP ba=300 -> pin_lc holds 040 for 3 edges, then 300 after release.
- TRAP with pin_tv=1 ta=6C0 -> 6C0. TRAP with pin_tv=0 at 6C0 -> 6C1 and pin_err=1. pin_rst asserted mid-CALL -> pin_lc=000, pin_sp=0, pin_err=0, pin_mv=0.
